// File: rtl/seg_minute_monitor.sv
// Seven-segment minute readback monitor: glitch-filters, decodes and step-checks the clock's minute display.
// Optional seconds plausibility checking is compiled in with `define SEG_MON_SEC_CHK_EN.
module seg_minute_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [7:0]       atog_h,
   input  logic [7:0]       atog_l,
   input  logic [3:0]       sec_h,
   input  logic [3:0]       sec_l,
   input  logic             err_clr,
   output logic [3:0]       min_h,
   output logic [3:0]       min_l,
   output logic [5:0]       min_bin,
   output logic             min_valid,
   output logic             tick,
   output logic             rollover,
   output logic             step_err,
   output logic             decode_err,
   output logic             sec_err,
   output logic [CNT_W-1:0] tick_cnt,
   output logic [CNT_W-1:0] resync_cnt
);

   localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
   localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      SYNC,
      TRACK,
      FAULT
   } state_t;

   state_t            state, state_nxt;
   logic [15:0]       samp;
   logic [STAB_W-1:0] stab_cnt;
   logic              acc;
   logic              same;

   logic [4:0]        dec_h, dec_l;
   logic              new_ok;
   logic [5:0]        new_bin;
   logic              is_inc, is_roll;

   logic              sec_bad, sec_edge;

   logic [3:0]        min_h_nxt, min_l_nxt;
   logic [5:0]        min_bin_nxt;
   logic              min_valid_nxt;
   logic              tick_nxt, rollover_nxt;
   logic              step_set, dec_set, tick_inc, resync_inc;
   logic              step_err_nxt, decode_err_nxt, sec_err_nxt;
   logic [CNT_W-1:0]  tick_cnt_nxt, resync_cnt_nxt;

   // Exact-match segment decode; returns {valid, digit}.
   function automatic logic [4:0] seg_decode(input logic [7:0] pat);
      logic [4:0] r;
      r = 5'b0_0000;
      case (pat)
         8'b0111_1110: r = {1'b1, 4'd0};
         8'b0001_0010: r = {1'b1, 4'd1};
         8'b1011_1100: r = {1'b1, 4'd2};
         8'b1011_0110: r = {1'b1, 4'd3};
         8'b1101_0010: r = {1'b1, 4'd4};
         8'b1110_0110: r = {1'b1, 4'd5};
         8'b1110_1110: r = {1'b1, 4'd6};
         8'b0011_0010: r = {1'b1, 4'd7};
         8'b1111_1110: r = {1'b1, 4'd8};
         8'b1111_0110: r = {1'b1, 4'd9};
         default:      r = 5'b0_0000;
      endcase
      return r;
   endfunction

   assign same = ({atog_h, atog_l} == samp);

   // acc is raised on the edge the stability count reaches its limit, so it fires once per stable period.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         samp     <= 16'h0000;
         stab_cnt <= '0;
         acc      <= 1'b0;
      end else begin
         samp <= {atog_h, atog_l};
         acc  <= 1'b0;
         if (!same) begin
            stab_cnt <= '0;
         end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + STAB_W'(1);
            if (stab_cnt == STAB_PRE) begin
               acc <= 1'b1;
            end
         end
      end
   end

   assign dec_h  = seg_decode(samp[15:8]);
   assign dec_l  = seg_decode(samp[7:0]);
   assign new_ok = dec_h[4] && dec_l[4] && (dec_h[3:0] <= 4'd5);

   // Tens is known to be <=5 whenever the result is used, so three bits suffice.
   assign new_bin = {dec_h[2:0], 3'b000} + {2'b00, dec_h[2:0], 1'b0} + {2'b00, dec_l[3:0]};

   assign is_inc  = (min_bin != 6'd59) && (new_bin == min_bin + 6'd1);
   assign is_roll = (min_bin == 6'd59) && (new_bin == 6'd0);

`ifdef SEG_MON_SEC_CHK_EN
   logic [3:0] sec_h_q, sec_l_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sec_h_q <= 4'd0;
         sec_l_q <= 4'd0;
      end else begin
         sec_h_q <= sec_h;
         sec_l_q <= sec_l;
      end
   end

   // Set-minute mode freezes the seconds at 00, so the 59/00 window also covers manual stepping.
   assign sec_bad  = (sec_h_q > 4'd5) || (sec_l_q > 4'd9);
   assign sec_edge = ((sec_h_q == 4'd0) && (sec_l_q == 4'd0)) ||
                     ((sec_h_q == 4'd5) && (sec_l_q == 4'd9));
`else
   logic unused_sec;
   assign unused_sec = ^{sec_h, sec_l};
   assign sec_bad    = 1'b0;
   assign sec_edge   = 1'b1;
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      min_h_nxt     = min_h;
      min_l_nxt     = min_l;
      min_bin_nxt   = min_bin;
      min_valid_nxt = min_valid;
      tick_nxt      = 1'b0;
      rollover_nxt  = 1'b0;
      step_set      = 1'b0;
      dec_set       = 1'b0;
      tick_inc      = 1'b0;
      resync_inc    = 1'b0;
      if (acc) begin
         case (state)
            TRACK: begin
               if (!new_ok) begin
                  dec_set       = 1'b1;
                  min_valid_nxt = 1'b0;
                  state_nxt     = FAULT;
               end else if (is_inc || is_roll) begin
                  tick_nxt     = 1'b1;
                  rollover_nxt = is_roll;
                  tick_inc     = 1'b1;
                  step_set     = !sec_edge;
                  min_h_nxt    = dec_h[3:0];
                  min_l_nxt    = dec_l[3:0];
                  min_bin_nxt  = new_bin;
               end else if (new_bin != min_bin) begin
                  step_set    = 1'b1;
                  resync_inc  = 1'b1;
                  min_h_nxt   = dec_h[3:0];
                  min_l_nxt   = dec_l[3:0];
                  min_bin_nxt = new_bin;
               end
            end
            default: begin
               if (new_ok) begin
                  min_h_nxt     = dec_h[3:0];
                  min_l_nxt     = dec_l[3:0];
                  min_bin_nxt   = new_bin;
                  min_valid_nxt = 1'b1;
                  state_nxt     = TRACK;
               end else begin
                  dec_set   = 1'b1;
                  state_nxt = FAULT;
               end
            end
         endcase
      end
   end

   // A set event in the same cycle as err_clr wins; counters then restart from the new event.
   always_comb begin
      step_err_nxt   = step_set ? 1'b1 : (err_clr ? 1'b0 : step_err);
      decode_err_nxt = dec_set  ? 1'b1 : (err_clr ? 1'b0 : decode_err);
      sec_err_nxt    = sec_bad  ? 1'b1 : (err_clr ? 1'b0 : sec_err);
      tick_cnt_nxt   = err_clr ? CNT_W'(tick_inc)   : tick_cnt   + CNT_W'(tick_inc);
      resync_cnt_nxt = err_clr ? CNT_W'(resync_inc) : resync_cnt + CNT_W'(resync_inc);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         min_h      <= 4'd0;
         min_l      <= 4'd0;
         min_bin    <= 6'd0;
         min_valid  <= 1'b0;
         tick       <= 1'b0;
         rollover   <= 1'b0;
         step_err   <= 1'b0;
         decode_err <= 1'b0;
         sec_err    <= 1'b0;
         tick_cnt   <= '0;
         resync_cnt <= '0;
      end else begin
         min_h      <= min_h_nxt;
         min_l      <= min_l_nxt;
         min_bin    <= min_bin_nxt;
         min_valid  <= min_valid_nxt;
         tick       <= tick_nxt;
         rollover   <= rollover_nxt;
         step_err   <= step_err_nxt;
         decode_err <= decode_err_nxt;
         sec_err    <= sec_err_nxt;
         tick_cnt   <= tick_cnt_nxt;
         resync_cnt <= resync_cnt_nxt;
      end
   end

endmodule

// File: doc/seg_minute_monitor.md
Name: seg_minute_monitor

Overview:
- Receiving end of the clock's minute display interface: takes the two 8-bit seven-segment minute patterns (tens, units) plus the BCD seconds digits.
- Filters glitches, decodes the patterns back to digits, and reconstructs the minute value.
- Checks that the minute advances by exactly +1 mod 60, reporting ticks, rollovers and faults.
- Sits beside the clock on the board/bench as a self-check and readback block.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern pair is accepted (>=1).
- CNT_W, 8: width of tick_cnt and resync_cnt.

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- atog_h  in  8  segment pattern, minute tens
- atog_l  in  8  segment pattern, minute units
- sec_h  in  4  BCD seconds tens
- sec_l  in  4  BCD seconds units
- err_clr  in  1  synchronous clear of sticky flags and counters
- min_h  out  4  decoded minute tens (BCD)
- min_l  out  4  decoded minute units (BCD)
- min_bin  out  6  minute value 0..59
- min_valid  out  1  minute outputs hold an accepted valid reading
- tick  out  1  one-cycle pulse on each accepted +1 minute step
- rollover  out  1  one-cycle pulse on accepted 59->00 step (asserted together with tick)
- step_err  out  1  sticky: accepted minute change was not +1 mod 60
- decode_err  out  1  sticky: stable unrecognised pattern
- sec_err  out  1  sticky: seconds BCD out of range (see Optional Feature)
- tick_cnt  out  CNT_W  count of tick pulses, wraps
- resync_cnt  out  CNT_W  count of non-+1 changes, wraps

Behaviour:
- Reset (clr_n=0, async): all outputs 0; state SYNC; sample and stability registers 0.
- Decode is exact match only, bit7..0:
  - 0=0111_1110, 1=0001_0010, 2=1011_1100, 3=1011_0110, 4=1101_0010
  - 5=1110_0110, 6=1110_1110, 7=0011_0010, 8=1111_1110, 9=1111_0110
  - Any other pattern, including 0000_0001 (blank/default), is invalid.
- Tens digit >5 counts as invalid.
- Filter: {atog_h,atog_l} registered every cycle; a stability counter resets to 0 on any change and saturates at STABLE_CYCLES.
- Acceptance fires exactly once per stable period, when the counter reaches STABLE_CYCLES.
- Latency: a pair held from sample edge k updates outputs/pulses on edge k+STABLE_CYCLES+1. A pair held fewer cycles is never accepted.
- State SYNC: valid acceptance -> load min_h/min_l/min_bin, min_valid=1, go TRACK, no tick, no step check. Invalid acceptance -> decode_err=1, go FAULT.
- State TRACK, valid acceptance:
  - new==old+1: tick pulse, tick_cnt+1.
  - old=59 and new=0: tick and rollover both pulse, tick_cnt+1.
  - new==old: no action.
  - Any other value: step_err=1, resync_cnt+1, outputs load new value; stay TRACK.
- State TRACK, invalid acceptance: decode_err=1, min_valid=0, go FAULT; minute outputs hold last valid value.
- State FAULT: valid acceptance -> load value, min_valid=1, go TRACK, no step check, no tick.
- err_clr=1: clears step_err, decode_err, sec_err, tick_cnt, resync_cnt next edge; state and minute outputs unaffected.
- err_clr and a set event in the same cycle: the set event wins and counters load 1.
- Counters wrap 2^CNT_W-1 -> 0 without flagging.
- Async reset mid-filter discards partial stability count; state returns to SYNC.

Optional Feature:
- Macro: SEG_MON_SEC_CHK_EN.
- Defined: sec_h/sec_l registered every cycle; sec_err set if sec_h>5 or sec_l>9 on any sampled cycle.
- Defined, additionally: in TRACK, a tick accepted while the sampled seconds are neither 59 nor 00 sets step_err; the clock's set-minute mode is the allowed exception while the seconds digits are frozen.
- Undefined: seconds inputs ignored, sec_err tied 0, step_err from minute checks only.

Test Plan:
- Reset, then hold atog_h=0111_1110, atog_l=1011_0110 for 6 cycles -> min_bin=3, min_valid=1 on edge 5 after first sample, no tick.
- From 03, apply 0000_0001 glitch on atog_l for 2 cycles, then 1101_0010 stable -> no decode_err; 04 accepted; tick one pulse; tick_cnt=1.
- From 59 (1110_0110 / 1111_0110), apply 00 stable -> tick and rollover pulse same cycle; min_bin=0.
- From 10, apply 12 -> step_err=1, resync_cnt=1, min_bin=12; then err_clr -> step_err=0, resync_cnt=0.
- Stable 1111_1110 on atog_h -> decode_err=1, min_valid=0, FAULT; then stable 20 -> min_valid=1, no tick, no step_err.
- Macro defined: sec_h=6 for one cycle -> sec_err=1; minute step 07->08 with seconds 30 -> step_err=1.
